multi_channel_seconds_timer: RTL and testbench
==============================================

// Module: multi_channel_seconds_timer
// PURPOSE
//   Bank of N_CH independent seconds timers driven by one system clock.
//   Each channel counts a programmable number of seconds from its start strobe,
//   in one-shot or periodic mode, and raises a one-cycle expiry pulse.
//   Cancel and retrigger are supported.
//   Sits between the control FSMs and the 10 kHz system clock domain as the
//   shared time base for all timeouts.
// PARAMETERS
//   CLK_PER_SEC  10000  clock cycles per second; >= 2
//   SEC_WIDTH    7      width of per-channel second count (max 2^SEC_WIDTH-1 s)
//   N_CH         4      number of independent channels; >= 1
// PORTS
//   clk               in   1              system clock, rising edge
//   reset             in   1              asynchronous, active-high; clears all state
//   seconds_to_count  in   N_CH*SEC_WIDTH ch i at [i*SEC_WIDTH +: SEC_WIDTH]; sampled on start[i]
//   periodic          in   N_CH           mode per channel, sampled on start[i] (1 = auto-reload)
//   start             in   N_CH           1-cycle strobe: load and (re)start channel i
//   cancel            in   N_CH           1-cycle strobe: stop channel i, no expiry pulse
//   busy              out  N_CH           channel i counting
//   time_finished     out  N_CH           1-cycle expiry pulse per channel
//   seconds_elapsed   out  N_CH*SEC_WIDTH whole seconds elapsed in current period, ch i slice
// BEHAVIOUR
// - Reset, async assert: busy = 0, time_finished = 0, seconds_elapsed = 0.
//   Cycle counters, latched targets and latched modes are also cleared.
// - Per channel: a cycle counter of width $clog2(CLK_PER_SEC), a seconds counter
//   of SEC_WIDTH bits, a latched target N and a latched mode. All outputs are registered.
// - States per channel: IDLE (busy=0) and RUN (busy=1).
// - Start, IDLE or RUN (retrigger), sampled at edge 0:
//   - N and mode are latched; cycle = 0; sec = 0; busy = 1.
//   - Nothing already in progress produces a pulse.
// - In RUN, each edge:
//   - cycle increments.
//   - When cycle == CLK_PER_SEC-1: cycle <= 0 and sec <= sec+1 (a "tick").
// - Expiry is the tick where sec+1 == N. At that edge:
//   - time_finished <= 1 for exactly one cycle.
//   - One-shot: go to IDLE, busy <= 0, seconds_elapsed holds N.
//   - Periodic: sec <= 0, cycle <= 0, stay in RUN.
// - Latency: start sampled at edge 0 gives time_finished high for the cycle after
//   edge N*CLK_PER_SEC. Periodic channels pulse again every N*CLK_PER_SEC cycles.
// - N == 0 at start:
//   - time_finished pulses after edge 1; busy stays 0.
//   - Periodic is ignored, so N = 0 behaves as one-shot.
// - Cancel in RUN: IDLE next edge, busy <= 0, no pulse.
//   Counters hold their values and seconds_elapsed freezes.
// - Cancel in IDLE: no effect.
// - Simultaneous events, same channel, same edge:
//   - cancel & start: cancel wins.
//   - start & expiry tick: start wins (restart, no pulse).
//   - cancel & expiry tick: cancel wins, no pulse.
// - Channels are fully independent; any combination of strobes across channels is legal.
// - Counters never wrap: an expiry always occurs at or before sec reaches N.
// - Reset mid-count: outputs clear immediately (asynchronously).
//   No pulse after reset release until a new start.
// TESTING (sim with CLK_PER_SEC=4, SEC_WIDTH=4, N_CH=2)
// 1. Reset released; ch0 start, N=3, one-shot at edge 0
//    -> busy0=1 edges 0..11; time_finished0 pulses one cycle after edge 12;
//       busy0=0 after; elapsed0=3.
// 2. ch1 periodic, N=2
//    -> pulses after edges 8, 16, 24; busy1 stays 1; elapsed1 cycles 0,1,0,1.
// 3. ch0 N=3 started, cancel at edge 6
//    -> busy0=0 after edge 6; elapsed0 frozen at 1; no pulse through edge 20.
// 4. Retrigger ch0 at edge 10 (N=3, first start at edge 0)
//    -> no pulse at edge 12; single pulse after edge 22.
// 5. ch0 start N=0; start and cancel same edge on ch1
//    -> time_finished0 pulses after edge 1 with busy0=0; ch1 stays IDLE.
// 6. Reset asserted mid-count at edge 5 with both channels running
//    -> all outputs 0 immediately; no pulse for 40 cycles after release.

Source files
------------

// File: rtl/multi_channel_seconds_timer.sv
// Bank of N_CH independent seconds timers on one system clock.
// Each channel supports one-shot or periodic mode, cancel and retrigger, and gives a one-cycle expiry pulse.
module multi_channel_seconds_timer #(
    parameter int unsigned CLK_PER_SEC = 10000,
    parameter int unsigned SEC_WIDTH   = 7,
    parameter int unsigned N_CH        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH*SEC_WIDTH-1:0] seconds_to_count,
    input  logic [N_CH-1:0]           periodic,
    input  logic [N_CH-1:0]           start,
    input  logic [N_CH-1:0]           cancel,
    output logic [N_CH-1:0]           busy,
    output logic [N_CH-1:0]           time_finished,
    output logic [N_CH*SEC_WIDTH-1:0] seconds_elapsed
);

    localparam int unsigned CYC_W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_PER_SEC - 1);

    // S_ZERO holds the deferred pulse for a start with N == 0; it is not busy
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ZERO = 2'd2
    } state_t;

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        state_t               r_state;
        state_t               w_state_nxt;
        logic [CYC_W-1:0]     r_cyc;
        logic [CYC_W-1:0]     w_cyc_nxt;
        logic [SEC_WIDTH-1:0] r_sec;
        logic [SEC_WIDTH-1:0] w_sec_nxt;
        logic [SEC_WIDTH-1:0] r_tgt;
        logic [SEC_WIDTH-1:0] w_tgt_nxt;
        logic                 r_per;
        logic                 w_per_nxt;
        logic                 r_busy;
        logic                 r_fin;
        logic                 w_fin_nxt;
        logic [SEC_WIDTH-1:0] w_n;
        logic [SEC_WIDTH-1:0] w_sec_inc;
        logic                 w_tick;
        logic                 w_expire;

        assign w_n       = seconds_to_count[g*SEC_WIDTH +: SEC_WIDTH];
        assign w_sec_inc = r_sec + SEC_WIDTH'(1);
        assign w_tick    = (r_cyc == CYC_LAST);
        assign w_expire  = w_tick && (w_sec_inc == r_tgt);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= S_IDLE;
                r_cyc   <= '0;
                r_sec   <= '0;
                r_tgt   <= '0;
                r_per   <= 1'b0;
                r_busy  <= 1'b0;
                r_fin   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cyc   <= w_cyc_nxt;
                r_sec   <= w_sec_nxt;
                r_tgt   <= w_tgt_nxt;
                r_per   <= w_per_nxt;
                r_busy  <= (w_state_nxt == S_RUN);
                r_fin   <= w_fin_nxt;
            end
        end

        // Priority: cancel, then start, then normal counting/expiry
        always_comb begin
            w_state_nxt = r_state;
            w_cyc_nxt   = r_cyc;
            w_sec_nxt   = r_sec;
            w_tgt_nxt   = r_tgt;
            w_per_nxt   = r_per;
            w_fin_nxt   = 1'b0;

            if (cancel[g]) begin
                w_state_nxt = S_IDLE;
            end else if (start[g]) begin
                w_tgt_nxt   = w_n;
                w_per_nxt   = periodic[g] && (w_n != '0);
                w_cyc_nxt   = '0;
                w_sec_nxt   = '0;
                w_state_nxt = (w_n == '0) ? S_ZERO : S_RUN;
            end else begin
                case (r_state)
                    S_ZERO: begin
                        w_fin_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                    S_RUN: begin
                        if (w_tick) begin
                            w_cyc_nxt = '0;
                            if (w_expire) begin
                                w_fin_nxt = 1'b1;
                                if (r_per) begin
                                    w_sec_nxt = '0;
                                end else begin
                                    w_sec_nxt   = w_sec_inc;
                                    w_state_nxt = S_IDLE;
                                end
                            end else begin
                                w_sec_nxt = w_sec_inc;
                            end
                        end else begin
                            w_cyc_nxt = r_cyc + CYC_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end

        assign busy[g]                                   = r_busy;
        assign time_finished[g]                          = r_fin;
        assign seconds_elapsed[g*SEC_WIDTH +: SEC_WIDTH] = r_sec;
    end

endmodule

// File: tb/tb_multi_channel_seconds_timer.sv
// Directed self-checking bench for multi_channel_seconds_timer (CLK_PER_SEC=4, SEC_WIDTH=4, N_CH=2).
module tb_multi_channel_seconds_timer;

    logic       clk;
    logic       reset;
    logic [7:0] stc;
    logic [1:0] per;
    logic [1:0] start;
    logic [1:0] cancel;
    logic [1:0] busy;
    logic [1:0] tf;
    logic [7:0] el;

    int n_checks;
    int n_fail;
    int bad;

    multi_channel_seconds_timer #(
        .CLK_PER_SEC(4),
        .SEC_WIDTH  (4),
        .N_CH       (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .seconds_to_count(stc),
        .periodic        (per),
        .start           (start),
        .cancel          (cancel),
        .busy            (busy),
        .time_finished   (tf),
        .seconds_elapsed (el)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start  = '0;
        cancel = '0;
        per    = '0;
        stc    = '0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_tf", tf, 0);
        check("rst_el", el, 0);

        // 1: ch0 one-shot N=3
        stc = 8'h03; per = 2'b00; start = 2'b01;
        step();
        start = '0;
        check("t1_busy_e0", busy[0], 1);
        check("t1_el_e0", el[3:0], 0);
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 4)  check("t1_el_e4", el[3:0], 1);
            if (e == 8)  check("t1_el_e8", el[3:0], 2);
            if (e < 12) begin
                check($sformatf("t1_busy_e%0d", e), busy[0], 1);
                check($sformatf("t1_tf_e%0d", e), tf[0], 0);
            end
        end
        check("t1_tf_e12", tf[0], 1);
        check("t1_busy_e12", busy[0], 0);
        check("t1_el_e12", el[3:0], 3);
        step();
        check("t1_tf_e13", tf[0], 0);
        check("t1_el_e13", el[3:0], 3);
        check("t1_ch1_idle", busy[1], 0);

        // 2: ch1 periodic N=2
        do_reset();
        stc = 8'h20; per = 2'b10; start = 2'b10;
        step();
        start = '0;
        check("t2_busy_e0", busy[1], 1);
        for (int e = 1; e <= 26; e++) begin
            step();
            check($sformatf("t2_tf_e%0d", e), tf[1], 32'((e % 8) == 0));
            check($sformatf("t2_busy_e%0d", e), busy[1], 1);
            check($sformatf("t2_el_e%0d", e), el[7:4], 32'((e / 4) % 2));
        end

        // 3: ch0 N=3, cancel at edge 6
        do_reset();
        stc = 8'h03; per = 2'b00; start = 2'b01;
        step();
        start = '0;
        repeat (5) step();
        cancel = 2'b01;
        step();
        cancel = '0;
        check("t3_busy_e6", busy[0], 0);
        check("t3_el_e6", el[3:0], 1);
        bad = 0;
        for (int e = 7; e <= 20; e++) begin
            step();
            if (tf[0] !== 1'b0 || el[3:0] !== 4'd1 || busy[0] !== 1'b0) bad++;
        end
        check("t3_frozen_e7_20", bad, 0);

        // 4: retrigger ch0 at edge 10
        do_reset();
        stc = 8'h03; per = 2'b00; start = 2'b01;
        step();
        start = '0;
        repeat (9) step();
        start = 2'b01;
        step();
        start = '0;
        check("t4_el_e10", el[3:0], 0);
        bad = 0;
        for (int e = 11; e <= 21; e++) begin
            step();
            if (e == 12) check("t4_tf_e12", tf[0], 0);
            if (e == 12) check("t4_busy_e12", busy[0], 1);
            if (tf[0] !== 1'b0) bad++;
        end
        check("t4_nopulse_e11_21", bad, 0);
        step();
        check("t4_tf_e22", tf[0], 1);
        check("t4_busy_e22", busy[0], 0);
        step();
        check("t4_tf_e23", tf[0], 0);

        // 5: ch0 N=0 (periodic ignored); ch1 start and cancel together
        do_reset();
        stc = 8'h20; per = 2'b11; start = 2'b11; cancel = 2'b10;
        step();
        start = '0; cancel = '0;
        check("t5_busy0_e0", busy[0], 0);
        check("t5_tf0_e0", tf[0], 0);
        check("t5_busy1_e0", busy[1], 0);
        step();
        check("t5_tf0_e1", tf[0], 1);
        check("t5_busy0_e1", busy[0], 0);
        bad = 0;
        for (int e = 2; e <= 12; e++) begin
            step();
            if (tf !== 2'b00 || busy !== 2'b00) bad++;
        end
        check("t5_quiet_e2_12", bad, 0);

        // 6: reset mid-count at edge 5
        do_reset();
        stc = 8'h23; per = 2'b10; start = 2'b11;
        step();
        start = '0;
        repeat (4) step();
        check("t6_busy_e4", busy, 3);
        check("t6_el0_e4", el[3:0], 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_busy_rst", busy, 0);
        check("t6_tf_rst", tf, 0);
        check("t6_el_rst", el, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int e = 0; e < 40; e++) begin
            step();
            if (tf !== 2'b00 || busy !== 2'b00 || el !== 8'h00) bad++;
        end
        check("t6_quiet_40", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
